// File: rtl/div_pkg.sv
// Shared definitions for the divider and the logic around it: default widths,
// the in-flight tag record and a constant-expression clog2.
package div_pkg;

    localparam int DIV_XDW   = 32;
    localparam int DIV_YDW   = 16;
    localparam int DIV_GRAIN = 2;
    localparam int DIV_PIPE  = 1;

    // Wide enough for the largest supported requester count (8).
    localparam int DIV_TAG_IDW = 3;

    typedef struct packed {
        logic [DIV_TAG_IDW-1:0] id;
        logic                   dz;
    } div_tag_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/div_arbiter_if.sv
// Requester, divider and result buses of the shared-divider arbiter.
// The slave modport is the arbiter's view; master is its environment.
interface div_arbiter_if
    import div_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2,
    parameter int XDW   = DIV_XDW,
    parameter int YDW   = DIV_YDW
);

    logic [N_REQ-1:0]     req_vld_i;
    logic [N_REQ*XDW-1:0] req_x_i;
    logic [N_REQ*YDW-1:0] req_y_i;
    logic [N_REQ-1:0]     req_rdy_o;

    logic [XDW-1:0]       div_x_o;
    logic [YDW-1:0]       div_y_o;
    logic                 div_dv_o;
    logic [XDW-1:0]       div_q_i;
    logic                 div_dv_i;

    logic [XDW-1:0]       res_q_o;
    logic [IDW-1:0]       res_id_o;
    logic                 res_dz_o;
    logic                 res_vld_o;

    modport slave (
        input  req_vld_i, req_x_i, req_y_i, div_q_i, div_dv_i,
        output req_rdy_o, div_x_o, div_y_o, div_dv_o,
               res_q_o, res_id_o, res_dz_o, res_vld_o
    );

    modport master (
        output req_vld_i, req_x_i, req_y_i, div_q_i, div_dv_i,
        input  req_rdy_o, div_x_o, div_y_o, div_dv_o,
               res_q_o, res_id_o, res_dz_o, res_vld_o
    );

endinterface

// File: rtl/div_tag_fifo.sv
// Small synchronous FIFO holding the tags of operations inside the divider.
// A pop frees a slot, so push is accepted when full if a pop happens alongside.
module div_tag_fifo
    import div_pkg::*;
#(
    parameter int W     = 3,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             push,
    input  logic [W-1:0]     push_data,
    input  logic             pop,
    output logic [W-1:0]     pop_data,
    output logic             full,
    output logic             empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int AW = (DEPTH > 1) ? clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   count_reg;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == (AW+1)'(DEPTH));
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];

    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage carries no reset; only the pointers define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/div_arbiter.sv
// Round-robin front end sharing one iterative divider between N_REQ requesters;
// results come back in issue order tagged with requester id and a div-by-zero flag.
module div_arbiter
    import div_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int IDW       = 2,
    parameter int XDW       = DIV_XDW,
    parameter int YDW       = DIV_YDW,
    parameter int ISSUE_GAP = 17,
    parameter int TAG_DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         en_i,
    div_arbiter_if.slave bus,
    output logic         busy_o,
    output logic         err_o
);

    localparam int GAPW = clog2(ISSUE_GAP + 1);
    localparam int CNTW = clog2(TAG_DEPTH) + 1;

    logic [XDW-1:0]   req_x_arr [N_REQ];
    logic [YDW-1:0]   req_y_arr [N_REQ];

    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   rr_ptr_next;
    logic [GAPW-1:0]  gap_reg;

    logic [XDW-1:0]   div_x_reg;
    logic [YDW-1:0]   div_y_reg;
    logic             div_dv_reg;

    logic [XDW-1:0]   res_q_reg;
    logic [IDW-1:0]   res_id_reg;
    logic             res_dz_reg;
    logic             res_vld_reg;
    logic             err_reg;

    logic [N_REQ-1:0] grant_onehot;
    logic [IDW-1:0]   grant_id;
    logic             grant_any;
    logic             grant_ok;
    logic             handshake;
    logic [IDW:0]     scan_sum;
    logic [IDW-1:0]   scan_idx;

    logic [IDW:0]     push_data;
    logic [IDW:0]     head_data;
    div_tag_t         head_tag;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNTW-1:0]  fifo_count;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign req_x_arr[gi] = bus.req_x_i[gi*XDW +: XDW];
        assign req_y_arr[gi] = bus.req_y_i[gi*YDW +: YDW];
    end

    // First valid requester at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_onehot = '0;
        grant_id     = '0;
        grant_any    = 1'b0;
        scan_sum     = '0;
        scan_idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            scan_sum = {1'b0, rr_ptr_reg} + (IDW+1)'(i);
            if (scan_sum >= (IDW+1)'(N_REQ)) begin
                scan_sum = scan_sum - (IDW+1)'(N_REQ);
            end
            scan_idx = scan_sum[IDW-1:0];
            if (!grant_any && bus.req_vld_i[scan_idx]) begin
                grant_any              = 1'b1;
                grant_onehot[scan_idx] = 1'b1;
                grant_id               = scan_idx;
            end
        end
    end

    // rstn_i gates the grant so req_rdy_o is low throughout reset even with valids up.
    assign grant_ok      = rstn_i & en_i & (gap_reg == '0) & ~fifo_full & grant_any;
    assign bus.req_rdy_o = grant_ok ? grant_onehot : '0;
    assign handshake     = |(bus.req_vld_i & bus.req_rdy_o);

    assign rr_ptr_next = (grant_id == IDW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;

    assign push_data   = {grant_id, (req_y_arr[grant_id] == '0)};
    assign head_tag.id = DIV_TAG_IDW'(head_data[IDW:1]);
    assign head_tag.dz = head_data[0];
    assign fifo_pop    = bus.div_dv_i & ~fifo_empty;

    div_tag_fifo #(
        .W     (IDW + 1),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .push      (handshake),
        .push_data (push_data),
        .pop       (fifo_pop),
        .pop_data  (head_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rr_ptr_reg  <= '0;
            gap_reg     <= '0;
            div_x_reg   <= '0;
            div_y_reg   <= '0;
            div_dv_reg  <= 1'b0;
            res_q_reg   <= '0;
            res_id_reg  <= '0;
            res_dz_reg  <= 1'b0;
            res_vld_reg <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            div_dv_reg <= handshake;
            if (handshake) begin
                div_x_reg  <= req_x_arr[grant_id];
                div_y_reg  <= req_y_arr[grant_id];
                gap_reg    <= GAPW'(ISSUE_GAP - 1);
                rr_ptr_reg <= rr_ptr_next;
            end else if (gap_reg != '0) begin
                gap_reg <= gap_reg - 1'b1;
            end

            // Zero divisors still go through the divider to keep result order;
            // their quotient is replaced here.
            res_vld_reg <= fifo_pop;
            if (fifo_pop) begin
                res_id_reg <= IDW'(head_tag.id);
                res_dz_reg <= head_tag.dz;
                res_q_reg  <= head_tag.dz ? '1 : bus.div_q_i;
            end

            if (bus.div_dv_i && fifo_empty) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign bus.div_x_o   = div_x_reg;
    assign bus.div_y_o   = div_y_reg;
    assign bus.div_dv_o  = div_dv_reg;
    assign bus.res_q_o   = res_q_reg;
    assign bus.res_id_o  = res_id_reg;
    assign bus.res_dz_o  = res_dz_reg;
    assign bus.res_vld_o = res_vld_reg;
    assign busy_o        = (fifo_count != '0) | div_dv_reg;
    assign err_o         = err_reg;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: stub divider with fixed latency, queue-based reference
// model of arbitration/results, table vectors and directed corner sequences.
module tb_div_arbiter;
    import div_pkg::*;

    localparam int N_REQ     = 4;
    localparam int IDW       = 2;
    localparam int XDW       = 32;
    localparam int YDW       = 16;
    localparam int ISSUE_GAP = 17;
    localparam int TAG_DEPTH = 4;
    localparam int DLAT      = 16;

    logic clk_i = 1'b0;
    logic rstn_i;
    logic en_i;
    logic busy_o;
    logic err_o;

    div_arbiter_if #(.N_REQ(N_REQ), .IDW(IDW), .XDW(XDW), .YDW(YDW)) bus ();

    div_arbiter #(
        .N_REQ(N_REQ), .IDW(IDW), .XDW(XDW), .YDW(YDW),
        .ISSUE_GAP(ISSUE_GAP), .TAG_DEPTH(TAG_DEPTH)
    ) dut (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .en_i   (en_i),
        .bus    (bus),
        .busy_o (busy_o),
        .err_o  (err_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [XDW-1:0] q;
        logic           dz;
        int             hs_cyc;
    } exp_t;

    typedef struct {
        logic [XDW-1:0] q;
        int             due;
    } op_t;

    typedef struct {
        int             req;
        logic [XDW-1:0] x;
        logic [YDW-1:0] y;
        logic [XDW-1:0] q;
        logic           dz;
    } vec_t;

    exp_t exp_q [$];
    op_t  stub_q [$];
    int   grant_log_id [$];
    int   grant_log_cyc [$];

    int             m_rr;
    int             m_cnt;
    int             m_last_issue;
    bit             m_err;
    bit             m_dv_pend;
    bit             m_res_pend;
    logic [XDW-1:0] m_x;
    logic [YDW-1:0] m_y;

    bit             hold;
    bit             release_one;
    bit             spurious;
    int             rel_cyc;

    bit             last_hs;
    int             last_k;
    bit             got_res;
    logic [XDW-1:0] last_q;
    logic [IDW-1:0] last_id;
    logic           last_dz;
    int             last_lat;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic set_operand(input int k, input logic [XDW-1:0] x, input logic [YDW-1:0] y);
        bus.req_x_i[k*XDW +: XDW] = x;
        bus.req_y_i[k*YDW +: YDW] = y;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdy"},    bus.req_rdy_o, '0);
        check({tag, "_div_dv"}, bus.div_dv_o, 0);
        check({tag, "_res_vld"}, bus.res_vld_o, 0);
        check({tag, "_busy"},   busy_o, 0);
        check({tag, "_err"},    err_o, 0);
        check({tag, "_div_x"},  bus.div_x_o, 0);
        check({tag, "_div_y"},  bus.div_y_o, 0);
        check({tag, "_res_q"},  bus.res_q_o, 0);
        check({tag, "_res_id"}, bus.res_id_o, 0);
        check({tag, "_res_dz"}, bus.res_dz_o, 0);
    endtask

    task automatic do_reset(input string tag);
        rstn_i = 1'b0;
        bus.div_dv_i = 1'b0;
        #1;
        check_reset_outputs(tag);
        exp_q.delete();
        stub_q.delete();
        grant_log_id.delete();
        grant_log_cyc.delete();
        m_rr = 0; m_cnt = 0; m_last_issue = -1000;
        m_err = 0; m_dv_pend = 0; m_res_pend = 0;
        hold = 0; release_one = 0; spurious = 0;
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    // One clock cycle: compare DUT against the model, advance model and stub divider.
    task automatic step();
        logic [N_REQ-1:0] exp_rdy;
        int               k;
        int               j;
        logic [XDW-1:0]   x;
        logic [YDW-1:0]   y;
        logic             dv;
        logic [XDW-1:0]   q;
        exp_t             e;
        op_t              op;
        #1;
        check("div_dv", bus.div_dv_o, m_dv_pend);
        if (m_dv_pend) begin
            check("div_x", bus.div_x_o, m_x);
            check("div_y", bus.div_y_o, m_y);
        end
        check("err", err_o, m_err);
        check("busy", busy_o, (m_cnt > 0) || m_dv_pend);
        check("res_vld", bus.res_vld_o, m_res_pend);
        if (bus.res_vld_o) begin
            $display("result id=%0d q=0x%08h dz=%0d cycle=%0d",
                     bus.res_id_o, bus.res_q_o, bus.res_dz_o, cyc);
            check("res_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("res_q", bus.res_q_o, e.q);
                check("res_id", bus.res_id_o, e.id);
                check("res_dz", bus.res_dz_o, e.dz);
                got_res  = 1;
                last_q   = bus.res_q_o;
                last_id  = bus.res_id_o;
                last_dz  = bus.res_dz_o;
                last_lat = cyc - e.hs_cyc;
            end
        end

        exp_rdy = '0;
        k = -1;
        if (en_i && (cyc - m_last_issue >= ISSUE_GAP) && (m_cnt < TAG_DEPTH)) begin
            for (int i = 0; i < N_REQ; i++) begin
                j = (m_rr + i) % N_REQ;
                if (k < 0 && bus.req_vld_i[j]) k = j;
            end
        end
        if (k >= 0) exp_rdy[k] = 1'b1;
        check("req_rdy", bus.req_rdy_o, exp_rdy);

        last_hs = (k >= 0);
        last_k  = k;
        if (k >= 0) begin
            x = bus.req_x_i[k*XDW +: XDW];
            y = bus.req_y_i[k*YDW +: YDW];
            e.id     = IDW'(k);
            e.dz     = (y == '0);
            e.q      = (y == '0) ? '1 : x / XDW'(y);
            e.hs_cyc = cyc;
            exp_q.push_back(e);
            m_x = x;
            m_y = y;
            m_rr = (k + 1) % N_REQ;
            m_last_issue = cyc;
            grant_log_id.push_back(k);
            grant_log_cyc.push_back(cyc);
        end

        if (bus.div_dv_o) begin
            op.q   = (bus.div_y_o == '0) ? 32'h1234_5678 : bus.div_x_o / XDW'(bus.div_y_o);
            op.due = cyc + DLAT;
            stub_q.push_back(op);
        end
        dv = 1'b0;
        q  = '0;
        if (spurious) begin
            dv = 1'b1;
            q  = $urandom;
            spurious = 0;
        end else if (stub_q.size() != 0 && stub_q[0].due <= cyc && (!hold || release_one)) begin
            op = stub_q.pop_front();
            dv = 1'b1;
            q  = op.q;
            if (release_one) begin
                release_one = 0;
                rel_cyc = cyc;
            end
        end
        bus.div_dv_i = dv;
        bus.div_q_i  = q;

        if (dv && m_cnt == 0) m_err = 1;
        m_res_pend = dv && (m_cnt > 0);
        m_cnt      = m_cnt + ((k >= 0) ? 1 : 0) - ((dv && m_cnt > 0) ? 1 : 0);
        m_dv_pend  = (k >= 0);

        @(negedge clk_i);
        cyc++;
    endtask

    // Step, then replace the operands of a requester that was just served.
    task automatic tick();
        step();
        if (last_hs) set_operand(last_k, $urandom, 16'($urandom_range(1, 65535)));
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (n < 300 && (exp_q.size() != 0 || m_cnt != 0 || m_dv_pend || m_res_pend || stub_q.size() != 0)) begin
            tick();
            n++;
        end
        tick();
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [7];
        int   base;
        int   rdy_seen;
        bit   hs_seen;

        vecs[0] = '{0, 32'd1000,       16'd7,     32'd142,        1'b0};
        vecs[1] = '{2, 32'd5,          16'd0,     32'hFFFF_FFFF,  1'b1};
        vecs[2] = '{3, 32'd9,          16'd3,     32'd3,          1'b0};
        vecs[3] = '{1, 32'hFFFF_FFFF,  16'd1,     32'hFFFF_FFFF,  1'b0};
        vecs[4] = '{0, 32'd0,          16'd5,     32'd0,          1'b0};
        vecs[5] = '{3, 32'd12345678,   16'd65535, 32'd188,        1'b0};
        vecs[6] = '{1, 32'd0,          16'd0,     32'hFFFF_FFFF,  1'b1};

        rstn_i = 1'b1;
        en_i   = 1'b1;
        bus.req_vld_i = '0;
        bus.req_x_i   = '0;
        bus.req_y_i   = '0;
        bus.div_dv_i  = 1'b0;
        bus.div_q_i   = '0;
        hold = 0; release_one = 0; spurious = 0; rel_cyc = -1;
        got_res = 0;
        #2;

        // All requesters valid from reset: rotation 0,1,2,3,0 at ISSUE_GAP spacing.
        for (int k = 0; k < N_REQ; k++) set_operand(k, $urandom, 16'($urandom_range(1, 65535)));
        bus.req_vld_i = '1;
        do_reset("rst0");
        for (int n = 0; n < 200 && grant_log_id.size() < 5; n++) tick();
        bus.req_vld_i = '0;
        check("rot_grant_count", grant_log_id.size(), 5);
        if (grant_log_id.size() >= 5) begin
            for (int i = 0; i < 5; i++) check($sformatf("rot_id%0d", i), grant_log_id[i], i % N_REQ);
            for (int i = 1; i < 5; i++) check($sformatf("rot_gap%0d", i), grant_log_cyc[i] - grant_log_cyc[i-1], ISSUE_GAP);
        end
        drain("rot");

        // Table vectors, one requester at a time.
        for (int i = 0; i < 7; i++) begin
            set_operand(vecs[i].req, vecs[i].x, vecs[i].y);
            bus.req_vld_i = '0;
            bus.req_vld_i[vecs[i].req] = 1'b1;
            hs_seen = 0;
            for (int n = 0; n < 60 && !hs_seen; n++) begin
                step();
                hs_seen = last_hs;
            end
            bus.req_vld_i = '0;
            check($sformatf("vec%0d_grant", i), hs_seen, 1);
            got_res = 0;
            for (int n = 0; n < 60 && !got_res; n++) step();
            check($sformatf("vec%0d_seen", i), got_res, 1);
            check($sformatf("vec%0d_q", i), last_q, vecs[i].q);
            check($sformatf("vec%0d_id", i), last_id, vecs[i].req);
            check($sformatf("vec%0d_dz", i), last_dz, vecs[i].dz);
            check($sformatf("vec%0d_latency", i), last_lat, DLAT + 2);
        end
        drain("vec");

        // Tag FIFO full: divider withholds results.
        hold = 1;
        bus.req_vld_i = '1;
        base = grant_log_id.size();
        for (int n = 0; n < 150 && grant_log_id.size() - base < 4; n++) tick();
        check("full_four_grants", grant_log_id.size() - base, 4);
        rdy_seen = 0;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (bus.req_rdy_o != '0) rdy_seen++;
        end
        check("full_blocks_rdy", rdy_seen, 0);
        release_one = 1;
        rel_cyc = -1;
        for (int n = 0; n < 20 && grant_log_id.size() - base < 5; n++) tick();
        check("full_fifth_grant", grant_log_id.size() - base, 5);
        check("full_grant_after_pop", grant_log_cyc[$] - rel_cyc, 1);
        hold = 0;
        bus.req_vld_i = '0;
        drain("full");

        // Issue enable low: in-flight op completes, no new grant, then immediate grant.
        bus.req_vld_i = 4'b0010;
        hs_seen = 0;
        for (int n = 0; n < 40 && !hs_seen; n++) begin
            tick();
            hs_seen = last_hs;
        end
        check("en_first_grant", hs_seen, 1);
        en_i = 1'b0;
        base = grant_log_id.size();
        for (int n = 0; n < 40; n++) tick();
        check("en_low_no_grant", grant_log_id.size() - base, 0);
        check("en_low_busy_idle", busy_o, 0);
        en_i = 1'b1;
        #1;
        check("en_high_rdy", bus.req_rdy_o, 4'b0010);
        tick();
        check("en_high_grant", grant_log_id.size() - base, 1);
        bus.req_vld_i = '0;
        drain("en");

        // Randomised traffic against the model.
        for (int n = 0; n < 800; n++) begin
            for (int k = 0; k < N_REQ; k++) begin
                set_operand(k, $urandom,
                            ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 65535)));
            end
            bus.req_vld_i = 4'($urandom);
            en_i = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 15) == 0) hold = ~hold;
            step();
        end
        en_i = 1'b1;
        hold = 0;
        bus.req_vld_i = '0;
        drain("rand");

        // Spurious divider strobe while idle.
        spurious = 1;
        step();
        check("spur_err", err_o, 1);
        check("spur_no_res", bus.res_vld_o, 0);
        step();
        check("spur_err_sticky", err_o, 1);

        // Reset with an operation in flight.
        bus.req_vld_i = 4'b0001;
        hs_seen = 0;
        for (int n = 0; n < 40 && !hs_seen; n++) begin
            tick();
            hs_seen = last_hs;
        end
        check("rst_mid_grant", hs_seen, 1);
        for (int n = 0; n < 5; n++) tick();
        do_reset("rst_mid");
        bus.req_vld_i = '0;
        for (int n = 0; n < 30; n++) tick();
        check("rst_mid_no_stale", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
